cpu_single_cycle: RTL and testbench
===================================

// Module: cpu_single_cycle
// PURPOSE
//  Single-cycle 32-bit MIPS subset CPU: every instruction fetches, decodes, executes and retires in one clk cycle.
//  Contains PC register, instruction memory instance b2v_im, 32x32 register file, ALU, control decode and data memory instance b2v_DM.
//  Benches preload programs and data hierarchically through b2v_im.memory[] and b2v_DM.memory[]; both names are mandatory.
//  Reports current PC, current opcode and signed add overflow to the bench.
// PARAMETERS
//  IMEM_WORDS  256  instruction memory depth in 32-bit words (b2v_im.memory[0:IMEM_WORDS-1])
//  DMEM_WORDS  256  data memory depth in 32-bit words (b2v_DM.memory[0:DMEM_WORDS-1])
// PORTS
//  clk       in   1   clock; all state updates on rising edge
//  rst       in   1   reset, asynchronous, active-low
//  Overflow  out  1   signed overflow of the current add/addi/sub result (combinational)
//  OPCODE    out  6   instr[31:26] of the instruction at PC (combinational)
//  PC        out  32  current program counter (byte address)
// BEHAVIOUR
//  - Reset (rst=0, async): PC=0; all 32 registers=0. Memories are NOT cleared, so preloaded contents survive reset.
//  - Memories are word arrays indexed by byte address >>2; out-of-range upper address bits are ignored.
//  - Reads are combinational: instr = b2v_im.memory[PC>>2]; load data = b2v_DM.memory[addr>>2].
//  - Writes occur on the rising clk edge while rst=1: register file, data memory, PC.
//  - Register $0 reads 0 always; writes to it are discarded.
//  - R-type (op 0), funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; rd <- result.
//  - slt: signed compare; rd = 1 if rs<rt, else 0.
//  - addi op 0x08: rt <- rs + signext(imm16).
//  - lw op 0x23: rt <- DM[(rs+signext(imm))>>2]. sw op 0x2B: DM[(rs+signext(imm))>>2] <- rt.
//  - beq op 0x04 / bne op 0x05: if (rs==rt) / (rs!=rt) then PC <- PC+4+(signext(imm)<<2), else PC <- PC+4.
//  - j op 0x02: PC <- {PC+4[31:28], target26, 2'b00}.
//  - All other instructions: PC <- PC+4, no register or memory write (NOP).
//  - Arithmetic wraps modulo 2^32. Overflow is a flag only: no trap, and the result is still written.
//  - Overflow = 1 only while the current instruction is add, addi or sub and operand signs imply signed overflow.
//  - Overflow = 0 for every other instruction and during reset.
//  - Overflow is valid within the cycle, so the bench samples it at the falling edge together with PC.
//  - PC wraps naturally at 2^32. Fetch past the loaded program returns whatever the memory holds.
//  - Reset asserted mid-program: PC returns to 0 immediately, registers clear, and memory keeps its contents.
// TESTING
//  - Reset: hold rst=0 with a preloaded IM, then release -> PC=0 and OPCODE=IM[0][31:26]. PC=4 after the 1st rising edge.
//  - addi/add/$zero: addi $s0,$zero,512; then addi $zero,$zero,5; then add $t0,$s0,$s0.
//    -> $s0=512, $zero=0, $t0=1024, Overflow=0 throughout.
//  - Bubble sort: 12 words at byte 512 = {55,88,0,22,77,11,99,33,110,66,121,44}.
//    Program uses addi/slt/beq/add/lw/sw/j only.
//    -> Overflow stays 0 for the whole run. DM[512..556] strictly ascending: {0,11,22,33,44,55,66,77,88,99,110,121}.
//  - Overflow: DM[560]=2^31-1; lw $t0,560($zero); addi $t0,$t0,1.
//    -> Overflow=1 while PC is at the addi. $t0=0x80000000 afterwards.
//  - Branch/jump: beq taken with imm=17 from PC=28 -> PC=100. beq with unequal operands -> PC=32.
//    bne inverse of both cases. j target 9 -> PC=36.
//  - Async reset mid-run: pull rst low between clock edges -> PC=0 at once without a clk edge. Previously stored DM words unchanged.

Source files
------------

// File: rtl/cpu_single_cycle.sv
// Single-cycle 32-bit MIPS-subset CPU.
// One instruction is fetched, decoded, executed and retired per clk cycle.
// Instruction memory (b2v_im) and data memory (b2v_DM) are word arrays named
// "memory" so a bench can preload programs and data hierarchically; neither
// memory is touched by reset.
// There is no handshake: every architectural update happens on the rising
// clk edge while rst is high, and all outputs are combinational views of the
// instruction currently addressed by the PC.

// Word-addressed memory with a combinational read port and a clocked write port.
module cpu_single_cycle_mem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] memory [0:WORDS-1];

  assign o_rdata = memory[i_idx];

  // Clocked word write; contents are never cleared.
  always_ff @(posedge i_clk) begin
    if (i_we) memory[i_idx] <= i_wdata;
  end
endmodule

module cpu_single_cycle #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        Overflow,
  output logic [5:0]  OPCODE,
  output logic [31:0] PC
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  logic [31:0] r_pc;
  logic [31:0] r_regs [0:31];

  logic [31:0] w_instr;
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [31:0] w_sext;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_res;
  logic        w_alu_ovf;
  logic [31:0] w_load_data;
  logic [31:0] w_wb_data;
  logic [31:0] w_pc4;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_pc_next;

  // Decoded control
  logic        w_reg_we;
  logic [4:0]  w_wa;
  logic        w_alu_b_imm;
  alu_op_e     w_alu_op;
  logic        w_mem_we;
  logic        w_mem_to_reg;
  logic        w_beq;
  logic        w_bne;
  logic        w_jump;
  logic        w_ovf_en;

  cpu_single_cycle_mem #(.WORDS(IMEM_WORDS)) b2v_im (
    .i_clk   (clk),
    .i_we    (1'b0),
    .i_idx   (r_pc[IAW+1:2]),
    .i_wdata (32'd0),
    .o_rdata (w_instr)
  );

  cpu_single_cycle_mem #(.WORDS(DMEM_WORDS)) b2v_DM (
    .i_clk   (clk),
    .i_we    (w_mem_we & rst),
    .i_idx   (w_alu_res[DAW+1:2]),
    .i_wdata (w_rt_val),
    .o_rdata (w_load_data)
  );

  assign w_op    = w_instr[31:26];
  assign w_rs    = w_instr[25:21];
  assign w_rt    = w_instr[20:16];
  assign w_rd    = w_instr[15:11];
  assign w_funct = w_instr[5:0];
  assign w_sext  = {{16{w_instr[15]}}, w_instr[15:0]};

  // $0 is hard-wired to zero on the read side as well as never being written.
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];
  assign w_alu_b  = w_alu_b_imm ? w_sext : w_rt_val;

  // Instruction decode into datapath controls; unknown encodings act as NOPs.
  always_comb begin
    w_reg_we     = 1'b0;
    w_wa         = w_rt;
    w_alu_b_imm  = 1'b0;
    w_alu_op     = ALU_ADD;
    w_mem_we     = 1'b0;
    w_mem_to_reg = 1'b0;
    w_beq        = 1'b0;
    w_bne        = 1'b0;
    w_jump       = 1'b0;
    w_ovf_en     = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_wa = w_rd;
        case (w_funct)
          FN_ADD: begin w_reg_we = 1'b1; w_alu_op = ALU_ADD; w_ovf_en = 1'b1; end
          FN_SUB: begin w_reg_we = 1'b1; w_alu_op = ALU_SUB; w_ovf_en = 1'b1; end
          FN_AND: begin w_reg_we = 1'b1; w_alu_op = ALU_AND; end
          FN_OR:  begin w_reg_we = 1'b1; w_alu_op = ALU_OR;  end
          FN_SLT: begin w_reg_we = 1'b1; w_alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ADDI: begin w_reg_we = 1'b1; w_alu_b_imm = 1'b1; w_ovf_en = 1'b1; end
      OP_LW:   begin w_reg_we = 1'b1; w_alu_b_imm = 1'b1; w_mem_to_reg = 1'b1; end
      OP_SW:   begin w_mem_we = 1'b1; w_alu_b_imm = 1'b1; end
      OP_BEQ:  w_beq  = 1'b1;
      OP_BNE:  w_bne  = 1'b1;
      OP_J:    w_jump = 1'b1;
      default: ;
    endcase
  end

  // ALU; overflow is derived from operand and result sign bits.
  always_comb begin
    w_alu_res = 32'd0;
    w_alu_ovf = 1'b0;
    case (w_alu_op)
      ALU_ADD: begin
        w_alu_res = w_rs_val + w_alu_b;
        w_alu_ovf = (w_rs_val[31] == w_alu_b[31]) && (w_alu_res[31] != w_rs_val[31]);
      end
      ALU_SUB: begin
        w_alu_res = w_rs_val - w_alu_b;
        w_alu_ovf = (w_rs_val[31] != w_alu_b[31]) && (w_alu_res[31] != w_rs_val[31]);
      end
      ALU_AND: w_alu_res = w_rs_val & w_alu_b;
      ALU_OR:  w_alu_res = w_rs_val | w_alu_b;
      ALU_SLT: w_alu_res = {31'd0, $signed(w_rs_val) < $signed(w_alu_b)};
      default: ;
    endcase
  end

  assign w_wb_data = w_mem_to_reg ? w_load_data : w_alu_res;

  assign w_pc4       = r_pc + 32'd4;
  assign w_br_target = w_pc4 + {w_sext[29:0], 2'b00};
  assign w_j_target  = {w_pc4[31:28], w_instr[25:0], 2'b00};

  // Next-PC selection: jump, taken branch, or fall-through.
  always_comb begin
    w_pc_next = w_pc4;
    if (w_jump)                               w_pc_next = w_j_target;
    else if (w_beq && (w_rs_val == w_rt_val)) w_pc_next = w_br_target;
    else if (w_bne && (w_rs_val != w_rt_val)) w_pc_next = w_br_target;
  end

  // Program counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pc <= 32'd0;
    else      r_pc <= w_pc_next;
  end

  // Register file write-back; writes to $0 are discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (w_reg_we && (w_wa != 5'd0)) begin
      r_regs[w_wa] <= w_wb_data;
    end
  end

  assign Overflow = rst & w_ovf_en & w_alu_ovf;
  assign OPCODE   = w_op;
  assign PC       = r_pc;
endmodule

// File: tb/tb_cpu_single_cycle.sv
// Bench for cpu_single_cycle: table-driven ALU vectors, directed sequences
// for reset, branch/jump, overflow, bubble sort and mid-run reset, and random
// programs checked every cycle against an instruction-level reference model.
module tb_cpu_single_cycle;
  logic        clk;
  logic        rst;
  logic        Overflow;
  logic [5:0]  OPCODE;
  logic [31:0] PC;

  int checks = 0;
  int errors = 0;
  logic saw_ovf;
  logic [38:0] exp_q[$];

  // Reference model state: architectural view only.
  logic [31:0] m_reg [32];
  logic [31:0] m_dm  [256];
  logic [31:0] m_im  [256];
  logic [31:0] m_pc;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_ovf;
  } vec_t;
  vec_t vecs [14];

  cpu_single_cycle #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .Overflow (Overflow),
    .OPCODE   (OPCODE),
    .PC       (PC)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic im_write(input int idx, input logic [31:0] v);
    m_im[idx] = v;
    dut.b2v_im.memory[idx] <= v;
  endtask

  task automatic dm_write(input int idx, input logic [31:0] v);
    m_dm[idx] = v;
    dut.b2v_DM.memory[idx] <= v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      im_write(i, 32'd0);
      dm_write(i, 32'd0);
    end
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    #1;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    saw_ovf = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic ovf_of(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Executes the instruction at m_pc: returns its overflow flag and commits its effect.
  task automatic model_exec(output logic ovf);
    logic [31:0] ins, a, b, sx, pc4, ea;
    logic [4:0]  rs, rt, rd;
    longint      s;
    ins = m_im[m_pc[9:2]];
    rs  = ins[25:21];
    rt  = ins[20:16];
    rd  = ins[15:11];
    a   = m_reg[rs];
    b   = m_reg[rt];
    sx  = {{16{ins[15]}}, ins[15:0]};
    ea  = a + sx;
    pc4 = m_pc + 32'd4;
    ovf = 1'b0;
    m_pc = pc4;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: begin s = longint'($signed(a)) + longint'($signed(b)); m_reg[rd] = s[31:0]; ovf = ovf_of(s); end
        6'h22: begin s = longint'($signed(a)) - longint'($signed(b)); m_reg[rd] = s[31:0]; ovf = ovf_of(s); end
        6'h24: m_reg[rd] = a & b;
        6'h25: m_reg[rd] = a | b;
        6'h2A: m_reg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: ;
      endcase
      6'h08: begin s = longint'($signed(a)) + longint'($signed(sx)); m_reg[rt] = s[31:0]; ovf = ovf_of(s); end
      6'h23: m_reg[rt] = m_dm[ea[9:2]];
      6'h2B: m_dm[ea[9:2]] = b;
      6'h04: if (a == b) m_pc = pc4 + (sx << 2);
      6'h05: if (a != b) m_pc = pc4 + (sx << 2);
      6'h02: m_pc = {pc4[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    m_reg[0] = 32'd0;
  endtask

  // Scoreboard: starts and ends at a falling edge, compares PC/OPCODE/Overflow each cycle.
  task automatic run_cycles(input int n, input string tag);
    logic [31:0] epc;
    logic [31:0] eins;
    logic        eovf;
    logic [38:0] exp;
    for (int c = 0; c < n; c++) begin
      #1;
      epc  = m_pc;
      eins = m_im[m_pc[9:2]];
      model_exec(eovf);
      exp_q.push_back({epc, eins[31:26], eovf});
      exp = exp_q.pop_front();
      checks++;
      if ({PC, OPCODE, Overflow} !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: PC %h OPCODE %h OVF %b, expected PC %h OPCODE %h OVF %b",
                 tag, c, PC, OPCODE, Overflow, exp[38:7], exp[6:1], exp[0]);
      end
      if (Overflow === 1'b1) saw_ovf = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic compare_state(input string tag);
    for (int i = 0; i < 32; i++) check32($sformatf("%s reg%0d", tag, i), dut.r_regs[i], m_reg[i]);
    for (int i = 0; i < 256; i++) check32($sformatf("%s dm%0d", tag, i), dut.b2v_DM.memory[i], m_dm[i]);
  endtask

  task automatic set_vec(input int k, input string nm, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e, input logic eo);
    vecs[k].name = nm; vecs[k].instr = ins; vecs[k].a = a; vecs[k].b = b;
    vecs[k].exp = e; vecs[k].exp_ovf = eo;
  endtask

  task automatic run_branch(input string nm, input logic [31:0] ins, input logic [31:0] exp_pc);
    hold_reset();
    clear_mem();
    im_write(0, enc_i(6'h08, 5'd0, 5'd8, 16'd1));
    im_write(7, ins);
    release_reset();
    run_cycles(7, nm);
    #1;
    check32({nm, " at"}, PC, 32'd28);
    @(negedge clk);
    #1;
    check32({nm, " next"}, PC, exp_pc);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] off;
    int k;
    logic [5:0] fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    k  = $urandom_range(0, 11);
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    off = 16'($urandom_range(0, 8)) - 16'd4;
    case (k)
      0, 1, 2, 3, 4: return enc_r(fns[k], rs, rt, rd);
      5:  return enc_i(6'h08, rs, rt, 16'($urandom));
      6:  return enc_i(6'h23, 5'd0, rt, 16'($urandom_range(0, 63) * 4));
      7:  return enc_i(6'h2B, 5'd0, rt, 16'($urandom_range(0, 63) * 4));
      8:  return enc_i(6'h04, rs, rt, off);
      9:  return enc_i(6'h05, rs, rt, off);
      10: return enc_j(26'($urandom_range(0, 47)));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] sorted [12];
  logic [31:0] unsorted [12];
  logic [31:0] bubble [18];
  logic        dummy_ovf;

  initial begin
    rst = 1'b0;
    // Vector table: $t1=a, $t2=b, result in $t3.
    set_vec(0,  "add_small",  enc_r(6'h20, 9, 10, 11), 32'd5,        32'd7,        32'd12,       1'b0);
    set_vec(1,  "add_posovf", enc_r(6'h20, 9, 10, 11), 32'h7fffffff, 32'd1,        32'h80000000, 1'b1);
    set_vec(2,  "add_negovf", enc_r(6'h20, 9, 10, 11), 32'h80000000, 32'h80000000, 32'd0,        1'b1);
    set_vec(3,  "sub_neg",    enc_r(6'h22, 9, 10, 11), 32'd5,        32'd7,        32'hfffffffe, 1'b0);
    set_vec(4,  "sub_ovf",    enc_r(6'h22, 9, 10, 11), 32'h80000000, 32'd1,        32'h7fffffff, 1'b1);
    set_vec(5,  "sub_ovf2",   enc_r(6'h22, 9, 10, 11), 32'h7fffffff, 32'hffffffff, 32'h80000000, 1'b1);
    set_vec(6,  "and",        enc_r(6'h24, 9, 10, 11), 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 1'b0);
    set_vec(7,  "or",         enc_r(6'h25, 9, 10, 11), 32'hf0f0f0f0, 32'hff00ff00, 32'hfff0fff0, 1'b0);
    set_vec(8,  "slt_true",   enc_r(6'h2A, 9, 10, 11), 32'hffffffff, 32'd1,        32'd1,        1'b0);
    set_vec(9,  "slt_false",  enc_r(6'h2A, 9, 10, 11), 32'd1,        32'hffffffff, 32'd0,        1'b0);
    set_vec(10, "addi_ovf",   enc_i(6'h08, 9, 11, 16'h0001), 32'h7fffffff, 32'd0,  32'h80000000, 1'b1);
    set_vec(11, "addi_neg",   enc_i(6'h08, 9, 11, 16'hfffb), 32'd10,       32'd0,  32'd5,        1'b0);
    set_vec(12, "addi_novf",  enc_i(6'h08, 9, 11, 16'hffff), 32'h80000000, 32'd0,  32'h7fffffff, 1'b1);
    set_vec(13, "bad_funct",  enc_r(6'h21, 9, 10, 11), 32'd3,        32'd4,        32'd0,        1'b0);

    // Reset and addi/add/$zero sequence
    hold_reset();
    clear_mem();
    im_write(0, enc_i(6'h08, 5'd0, 5'd16, 16'd512));
    im_write(1, enc_i(6'h08, 5'd0, 5'd0, 16'd5));
    im_write(2, enc_r(6'h20, 5'd16, 5'd16, 5'd8));
    @(negedge clk);
    #1;
    check32("reset pc held", PC, 32'd0);
    check32("reset ovf held", {31'd0, Overflow}, 32'd0);
    release_reset();
    #1;
    check32("reset pc", PC, 32'd0);
    check32("reset opcode", {26'd0, OPCODE}, 32'h08);
    model_exec(dummy_ovf);
    @(posedge clk);
    #1;
    check32("pc after 1st edge", PC, 32'd4);
    @(negedge clk);
    run_cycles(4, "addi_seq");
    check32("s0", dut.r_regs[16], 32'd512);
    check32("zero", dut.r_regs[0], 32'd0);
    check32("t0", dut.r_regs[8], 32'd1024);
    check32("addi_seq ovf", {31'd0, saw_ovf}, 32'd0);

    // Table-driven ALU vectors
    for (int v = 0; v < 14; v++) begin
      hold_reset();
      clear_mem();
      dm_write(0, vecs[v].a);
      dm_write(1, vecs[v].b);
      im_write(0, enc_i(6'h23, 5'd0, 5'd9, 16'd0));
      im_write(1, enc_i(6'h23, 5'd0, 5'd10, 16'd4));
      im_write(2, vecs[v].instr);
      release_reset();
      run_cycles(2, vecs[v].name);
      #1;
      check32({vecs[v].name, " ovf"}, {31'd0, Overflow}, {31'd0, vecs[v].exp_ovf});
      @(negedge clk);
      #1;
      check32({vecs[v].name, " result"}, dut.r_regs[11], vecs[v].exp);
    end

    // Overflow through lw/addi
    hold_reset();
    clear_mem();
    dm_write(140, 32'h7fffffff);
    im_write(0, enc_i(6'h23, 5'd0, 5'd8, 16'd560));
    im_write(1, enc_i(6'h08, 5'd8, 5'd8, 16'd1));
    release_reset();
    run_cycles(1, "ovf_seq");
    #1;
    check32("ovf_seq pc", PC, 32'd4);
    check32("ovf_seq flag", {31'd0, Overflow}, 32'd1);
    @(negedge clk);
    #1;
    check32("ovf_seq t0", dut.r_regs[8], 32'h80000000);

    // Branch and jump targets
    run_branch("beq_taken",  enc_i(6'h04, 5'd0, 5'd0, 16'd17), 32'd100);
    run_branch("beq_not",    enc_i(6'h04, 5'd8, 5'd0, 16'd17), 32'd32);
    run_branch("bne_taken",  enc_i(6'h05, 5'd8, 5'd0, 16'd17), 32'd100);
    run_branch("bne_not",    enc_i(6'h05, 5'd0, 5'd0, 16'd17), 32'd32);
    run_branch("beq_back",   enc_i(6'h04, 5'd0, 5'd0, 16'hfff8), 32'd0);
    hold_reset();
    clear_mem();
    im_write(0, enc_j(26'd9));
    release_reset();
    run_cycles(1, "jump");
    #1;
    check32("jump pc", PC, 32'd36);

    // Bubble sort of 12 words at byte 512
    unsorted = '{55, 88, 0, 22, 77, 11, 99, 33, 110, 66, 121, 44};
    sorted   = '{0, 11, 22, 33, 44, 55, 66, 77, 88, 99, 110, 121};
    bubble[0]  = enc_i(6'h08, 0, 16, 16'd512);
    bubble[1]  = enc_i(6'h08, 0, 17, 16'd11);
    bubble[2]  = enc_i(6'h04, 17, 0, 16'd14);
    bubble[3]  = enc_i(6'h08, 16, 8, 16'd0);
    bubble[4]  = enc_i(6'h08, 0, 9, 16'd0);
    bubble[5]  = enc_i(6'h04, 9, 17, 16'd9);
    bubble[6]  = enc_i(6'h23, 8, 10, 16'd0);
    bubble[7]  = enc_i(6'h23, 8, 11, 16'd4);
    bubble[8]  = enc_r(6'h2A, 11, 10, 12);
    bubble[9]  = enc_i(6'h04, 12, 0, 16'd2);
    bubble[10] = enc_i(6'h2B, 8, 11, 16'd0);
    bubble[11] = enc_i(6'h2B, 8, 10, 16'd4);
    bubble[12] = enc_i(6'h08, 8, 8, 16'd4);
    bubble[13] = enc_i(6'h08, 9, 9, 16'd1);
    bubble[14] = enc_j(26'd5);
    bubble[15] = enc_i(6'h08, 17, 17, 16'hffff);
    bubble[16] = enc_j(26'd2);
    bubble[17] = enc_j(26'd17);
    hold_reset();
    clear_mem();
    for (int i = 0; i < 18; i++) im_write(i, bubble[i]);
    for (int i = 0; i < 12; i++) dm_write(128 + i, unsorted[i]);
    release_reset();
    run_cycles(900, "bubble");
    for (int i = 0; i < 12; i++) check32($sformatf("sorted[%0d]", i), dut.b2v_DM.memory[128 + i], sorted[i]);
    check32("bubble ovf", {31'd0, saw_ovf}, 32'd0);
    check32("bubble halt pc", PC, 32'd68);
    compare_state("bubble");

    // Asynchronous reset between edges
    hold_reset();
    clear_mem();
    im_write(0, enc_i(6'h08, 5'd0, 5'd16, 16'd512));
    im_write(1, enc_i(6'h08, 5'd0, 5'd0, 16'd5));
    im_write(2, enc_r(6'h20, 5'd16, 5'd16, 5'd8));
    im_write(3, enc_i(6'h2B, 5'd0, 5'd8, 16'd600));
    release_reset();
    run_cycles(6, "async_pre");
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check32("async pc", PC, 32'd0);
    check32("async t0", dut.r_regs[8], 32'd0);
    check32("async s0", dut.r_regs[16], 32'd0);
    check32("async ovf", {31'd0, Overflow}, 32'd0);
    check32("async dm kept", dut.b2v_DM.memory[150], 32'd1024);

    // Random programs against the reference model
    for (int r = 0; r < 3; r++) begin
      hold_reset();
      clear_mem();
      for (int i = 0; i < 40; i++) im_write(i, rand_instr());
      for (int i = 0; i < 256; i++) dm_write(i, $urandom);
      release_reset();
      run_cycles(300, $sformatf("rand%0d", r));
      compare_state($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
